// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: memory byte-read channel, instruction handshake to the core,
// and hold/jump control.
interface instr_fetch_if #(
    parameter int ADDR_W = 8
);
    // A handshake moves data only on a cycle where both sides agree:
    // a memory byte transfers when o_mem_read && i_mem_ready, and an instruction
    // transfers when o_instr_ready && i_instr_read. Otherwise the transfer does not happen.
    logic              o_mem_read;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              i_mem_ready;
    logic [7:0]        i_mem_data;
    logic              o_instr_ready;
    logic [7:0]        o_opcode;
    logic [7:0]        o_arg1;
    logic [7:0]        o_arg2;
    logic [ADDR_W-1:0] o_instr_pc;
    logic              i_instr_read;
    logic              i_hold;
    logic              i_jump;
    logic [ADDR_W-1:0] i_jump_addr;

    modport master (
        output o_mem_read, o_mem_addr, o_instr_ready, o_opcode, o_arg1, o_arg2, o_instr_pc,
        input  i_mem_ready, i_mem_data, i_instr_read, i_hold, i_jump, i_jump_addr
    );

    modport slave (
        input  o_mem_read, o_mem_addr, o_instr_ready, o_opcode, o_arg1, o_arg2, o_instr_pc,
        output i_mem_ready, i_mem_data, i_instr_read, i_hold, i_jump, i_jump_addr
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: walks the PC through byte memory, assembles 3-byte instructions
// and feeds them to the core through a small prefetch queue.
module instr_fetch #(
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    instr_fetch_if.master            bus,
    output logic [1:0]               o_dbg_byte_idx,
    output logic [$clog2(DEPTH):0]   o_dbg_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {B0 = 2'd0, B1 = 2'd1, B2 = 2'd2} byte_idx_t;

    byte_idx_t         r_byte_idx, w_byte_idx_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [7:0]        r_op, r_a1;
    logic [ADDR_W-1:0] r_op_pc;

    logic [7:0]        r_q_op [DEPTH];
    logic [7:0]        r_q_a1 [DEPTH];
    logic [7:0]        r_q_a2 [DEPTH];
    logic [ADDR_W-1:0] r_q_pc [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
    logic [PTR_W:0]    r_count;

    logic w_mem_read, w_accept, w_push, w_pop;

    // Slot is only checked at B0; a started instruction already owns its slot.
    assign w_mem_read = !i_rst && !bus.i_hold && !bus.i_jump &&
                        (r_byte_idx != B0 || r_count < CNT_FULL);
    assign w_accept   = w_mem_read && bus.i_mem_ready;
    assign w_push     = w_accept && (r_byte_idx == B2);
    assign w_pop      = bus.i_instr_read && (r_count != '0);

    always_comb begin
        w_byte_idx_nxt = r_byte_idx;
        w_pc_nxt       = r_pc;
        if (bus.i_jump) begin
            w_byte_idx_nxt = B0;
            w_pc_nxt       = bus.i_jump_addr;
        end else if (w_accept) begin
            w_pc_nxt = r_pc + 1'b1;
            case (r_byte_idx)
                B0:      w_byte_idx_nxt = B1;
                B1:      w_byte_idx_nxt = B2;
                default: w_byte_idx_nxt = B0;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_byte_idx <= B0;
            r_pc       <= ADDR_W'(RESET_PC);
        end else begin
            r_byte_idx <= w_byte_idx_nxt;
            r_pc       <= w_pc_nxt;
        end
    end

    // Assembly registers and queue; jump wins over push and pop in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op     <= '0;
            r_a1     <= '0;
            r_op_pc  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_op[i] <= '0;
                r_q_a1[i] <= '0;
                r_q_a2[i] <= '0;
                r_q_pc[i] <= '0;
            end
        end else if (bus.i_jump) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept && r_byte_idx == B0) begin
                r_op    <= bus.i_mem_data;
                r_op_pc <= r_pc;
            end
            if (w_accept && r_byte_idx == B1) r_a1 <= bus.i_mem_data;
            if (w_push) begin
                r_q_op[r_wr_ptr] <= r_op;
                r_q_a1[r_wr_ptr] <= r_a1;
                r_q_a2[r_wr_ptr] <= bus.i_mem_data;
                r_q_pc[r_wr_ptr] <= r_op_pc;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.o_mem_read    = w_mem_read;
    assign bus.o_mem_addr    = r_pc;
    assign bus.o_instr_ready = (r_count != '0);
    assign bus.o_opcode      = r_q_op[r_rd_ptr];
    assign bus.o_arg1        = r_q_a1[r_rd_ptr];
    assign bus.o_arg2        = r_q_a2[r_rd_ptr];
    assign bus.o_instr_pc    = r_q_pc[r_rd_ptr];
    assign o_dbg_byte_idx    = r_byte_idx;
    assign o_dbg_count       = r_count;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: two instances, one at RESET_PC=0 and one at RESET_PC=0xFF.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic rst, rst2;
    logic [7:0] mem [256];
    logic [1:0] dbg_idx, dbg_idx2;
    logic [1:0] dbg_cnt, dbg_cnt2;
    int errors = 0;
    int checks = 0;

    instr_fetch_if #(.ADDR_W(8)) bus1 ();
    instr_fetch_if #(.ADDR_W(8)) bus2 ();

    instr_fetch #(.ADDR_W(8), .DEPTH(2), .RESET_PC(0)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus1.master),
        .o_dbg_byte_idx(dbg_idx), .o_dbg_count(dbg_cnt)
    );

    instr_fetch #(.ADDR_W(8), .DEPTH(2), .RESET_PC(255)) dut2 (
        .i_clk(clk), .i_rst(rst2), .bus(bus2.master),
        .o_dbg_byte_idx(dbg_idx2), .o_dbg_count(dbg_cnt2)
    );

    always #5 clk = ~clk;

    assign bus1.i_mem_data = mem[bus1.o_mem_addr];
    assign bus2.i_mem_data = mem[bus2.o_mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[0] = 8'h07; mem[1] = 8'h01; mem[2] = 8'h02;
        mem[3] = 8'h08; mem[4] = 8'h03; mem[5] = 8'h04;

        rst = 1'b0; rst2 = 1'b0;
        bus1.i_mem_ready = 1'b1; bus1.i_instr_read = 1'b0; bus1.i_hold = 1'b0;
        bus1.i_jump = 1'b0; bus1.i_jump_addr = 8'h00;
        bus2.i_mem_ready = 1'b1; bus2.i_instr_read = 1'b0; bus2.i_hold = 1'b0;
        bus2.i_jump = 1'b0; bus2.i_jump_addr = 8'h00;
        #1 rst = 1'b1; rst2 = 1'b1;
        #1;
        check("rst_mem_read", bus1.o_mem_read, 0);
        check("rst_instr_ready", bus1.o_instr_ready, 0);
        check("rst_opcode", bus1.o_opcode, 0);
        check("rst_instr_pc", bus1.o_instr_pc, 0);
        check("rst_mem_addr", bus1.o_mem_addr, 0);
        tick();
        rst = 1'b0;
        #1;
        check("start_req", {bus1.o_mem_read, bus1.o_mem_addr}, {1'b1, 8'h00});

        // Stream with memory always ready.
        tick();
        check("b1_addr", bus1.o_mem_addr, 1);
        check("b1_ready_low", bus1.o_instr_ready, 0);
        tick(); tick();
        check("i0_ready", bus1.o_instr_ready, 1);
        check("i0_bytes", {bus1.o_opcode, bus1.o_arg1, bus1.o_arg2}, 24'h070102);
        check("i0_pc", bus1.o_instr_pc, 0);
        tick(); tick(); tick();
        check("full_count", dbg_cnt, 2);
        check("full_no_read", bus1.o_mem_read, 0);
        check("full_addr", bus1.o_mem_addr, 6);
        tick();
        check("full_addr_stays", bus1.o_mem_addr, 6);

        // Pop one entry.
        bus1.i_instr_read = 1'b1;
        tick();
        bus1.i_instr_read = 1'b0;
        #1;
        check("i1_bytes", {bus1.o_opcode, bus1.o_arg1, bus1.o_arg2}, 24'h080304);
        check("i1_pc", bus1.o_instr_pc, 3);
        check("refetch_req", {bus1.o_mem_read, bus1.o_mem_addr}, {1'b1, 8'h06});

        // Wait states on byte 1.
        tick();
        check("ws_b1_addr", bus1.o_mem_addr, 7);
        bus1.i_mem_ready = 1'b0;
        tick();
        check("ws_hold1", {bus1.o_mem_read, bus1.o_mem_addr}, {1'b1, 8'h07});
        tick();
        check("ws_hold2", {bus1.o_mem_read, bus1.o_mem_addr, 6'(dbg_idx)}, {1'b1, 8'h07, 6'd1});
        bus1.i_mem_ready = 1'b1;
        tick(); tick();
        check("ws_count", dbg_cnt, 2);
        check("ws_head_kept", bus1.o_instr_pc, 3);
        bus1.i_instr_read = 1'b1;
        tick();
        bus1.i_instr_read = 1'b0;
        #1;
        check("ws_bytes", {bus1.o_opcode, bus1.o_arg1, bus1.o_arg2}, {mem[6], mem[7], mem[8]});
        check("ws_pc", bus1.o_instr_pc, 6);
        check("ws_next_addr", {bus1.o_mem_read, bus1.o_mem_addr}, {1'b1, 8'h09});

        // Jump during B2 with concurrent pop and a returned byte.
        tick(); tick();
        check("pre_jump_idx", dbg_idx, 2);
        bus1.i_jump = 1'b1; bus1.i_jump_addr = 8'h40; bus1.i_instr_read = 1'b1;
        #1;
        check("jump_no_read", bus1.o_mem_read, 0);
        tick();
        bus1.i_jump = 1'b0; bus1.i_instr_read = 1'b0;
        #1;
        check("jump_empty", bus1.o_instr_ready, 0);
        check("jump_count", dbg_cnt, 0);
        check("jump_req", {bus1.o_mem_read, bus1.o_mem_addr, 6'(dbg_idx)}, {1'b1, 8'h40, 6'd0});
        tick(); tick(); tick();
        check("jump_i_ready", bus1.o_instr_ready, 1);
        check("jump_i_pc", bus1.o_instr_pc, 8'h40);
        check("jump_i_bytes", {bus1.o_opcode, bus1.o_arg1, bus1.o_arg2}, {mem[8'h40], mem[8'h41], mem[8'h42]});

        // Hold after byte B0 of next instruction accepted (now in B1), one queued entry.
        tick();
        check("hold_pre_idx", dbg_idx, 1);
        bus1.i_hold = 1'b1;
        #1;
        check("hold_no_read", bus1.o_mem_read, 0);
        bus1.i_instr_read = 1'b1;
        tick();
        check("hold_drained", bus1.o_instr_ready, 0);
        tick();
        bus1.i_instr_read = 1'b0;
        #1;
        check("hold_empty_pop", dbg_cnt, 0);
        check("hold_state", {bus1.o_mem_addr, 6'(dbg_idx)}, {8'h44, 6'd1});
        bus1.i_hold = 1'b0;
        #1;
        check("hold_resume", {bus1.o_mem_read, bus1.o_mem_addr}, {1'b1, 8'h44});
        tick(); tick();
        check("hold_i_ready", bus1.o_instr_ready, 1);
        check("hold_i_pc", bus1.o_instr_pc, 8'h43);
        check("hold_i_bytes", {bus1.o_opcode, bus1.o_arg1, bus1.o_arg2}, {mem[8'h43], mem[8'h44], mem[8'h45]});

        // Second instance: wrap-around fetch from RESET_PC=0xFF, then async reset mid-fetch.
        rst2 = 1'b0;
        #1;
        check("wrap_start", {bus2.o_mem_read, bus2.o_mem_addr}, {1'b1, 8'hFF});
        tick();
        check("wrap_addr0", bus2.o_mem_addr, 8'h00);
        tick(); tick();
        check("wrap_ready", bus2.o_instr_ready, 1);
        check("wrap_pc", bus2.o_instr_pc, 8'hFF);
        check("wrap_bytes", {bus2.o_opcode, bus2.o_arg1, bus2.o_arg2}, {mem[8'hFF], mem[8'h00], mem[8'h01]});
        tick();
        #2 rst2 = 1'b1;
        #1;
        check("rst2_mem_read", bus2.o_mem_read, 0);
        check("rst2_ready", bus2.o_instr_ready, 0);
        check("rst2_bytes", {bus2.o_opcode, bus2.o_arg1, bus2.o_arg2}, 24'h000000);
        check("rst2_pc", bus2.o_instr_pc, 0);
        check("rst2_addr", {bus2.o_mem_addr, 6'(dbg_idx2), 6'(dbg_cnt2)}, {8'hFF, 6'd0, 6'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
